// File: rtl/mandbort_cluster_sched.sv
// Frame scheduler for a bank of mandbort clusters: gives each cluster one horizontal band,
// launches them together and merges their results into a single addressed pixel stream.
module mandbort_cluster_sched #(
  parameter int NUM_CLUSTER = 4,
  parameter int WIDTH       = 16,
  parameter int ITERW       = 7,
  parameter int XCNT_SIZE   = 10,
  parameter int YCNT_SIZE   = 10,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDRW       = $clog2(H_RES*V_RES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             start_x,
  input  logic [WIDTH-1:0]             start_y,
  input  logic [WIDTH-1:0]             delta_x,
  input  logic [WIDTH-1:0]             delta_y,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_CLUSTER-1:0]       cl_start,
  output logic [WIDTH-1:0]             cl_start_x,
  output logic [WIDTH-1:0]             cl_delta_x,
  output logic [WIDTH-1:0]             cl_delta_y,
  output logic [NUM_CLUSTER*WIDTH-1:0] cl_start_y,
  output logic [XCNT_SIZE-1:0]         cl_x_count,
  output logic [YCNT_SIZE-1:0]         cl_y_count,
  input  logic [NUM_CLUSTER-1:0]       cl_iter_vld,
  input  logic [NUM_CLUSTER*ITERW-1:0] cl_iter,
  input  logic [NUM_CLUSTER-1:0]       cl_done,
  output logic [NUM_CLUSTER-1:0]       cl_stall,
  output logic                         pix_vld,
  input  logic                         pix_rdy,
  output logic [ADDRW-1:0]             pix_addr,
  output logic [ITERW-1:0]             pix_iter
);

  localparam int BAND_ROWS = V_RES / NUM_CLUSTER;
  localparam int BAND_PIX  = BAND_ROWS * H_RES;
  localparam int PTRW      = (NUM_CLUSTER > 1) ? $clog2(NUM_CLUSTER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic [WIDTH-1:0]         startX_q, startX_d;
  logic [WIDTH-1:0]         deltaX_q, deltaX_d;
  logic [WIDTH-1:0]         deltaY_q, deltaY_d;
  logic [WIDTH-1:0]         acc_q, acc_d;
  logic [PTRW-1:0]          cfgIdx_q, cfgIdx_d;
  logic [NUM_CLUSTER*WIDTH-1:0] clStartY_q, clStartY_d;
  logic [NUM_CLUSTER-1:0]   bufFull_q, bufFull_d;
  logic [ITERW-1:0]         bufIter_q [NUM_CLUSTER];
  logic [ITERW-1:0]         bufIter_d [NUM_CLUSTER];
  logic [NUM_CLUSTER-1:0]   doneFlag_q, doneFlag_d;
  logic [ADDRW-1:0]         pixCnt_q [NUM_CLUSTER];
  logic [ADDRW-1:0]         pixCnt_d [NUM_CLUSTER];
  logic [PTRW-1:0]          rrPtr_q, rrPtr_d;
  logic                     pixVld_q, pixVld_d;
  logic [ADDRW-1:0]         pixAddr_q, pixAddr_d;
  logic [ITERW-1:0]         pixIter_q, pixIter_d;

  logic [WIDTH-1:0]         stepY;
  logic                     outFree;
  logic                     found;
  logic [PTRW-1:0]          grant;

  function automatic logic [ADDRW-1:0] bandBase(input int k);
    return ADDRW'(k * BAND_PIX);
  endfunction

  // Band-to-band imaginary step; wraps modulo 2^WIDTH like the cluster datapath.
  assign stepY = deltaY_q * WIDTH'(BAND_ROWS);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    startX_d   = startX_q;
    deltaX_d   = deltaX_q;
    deltaY_d   = deltaY_q;
    acc_d      = acc_q;
    cfgIdx_d   = cfgIdx_q;
    clStartY_d = clStartY_q;
    bufFull_d  = bufFull_q;
    bufIter_d  = bufIter_q;
    doneFlag_d = doneFlag_q;
    pixCnt_d   = pixCnt_q;
    rrPtr_d    = rrPtr_q;
    pixVld_d   = pixVld_q;
    pixAddr_d  = pixAddr_q;
    pixIter_d  = pixIter_q;
    outFree    = !pixVld_q || pix_rdy;
    found      = 1'b0;
    grant      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          startX_d = start_x;
          deltaX_d = delta_x;
          deltaY_d = delta_y;
          acc_d    = start_y;
          cfgIdx_d = '0;
          busy_d   = 1'b1;
          state_d  = S_CONFIG;
        end
      end
      S_CONFIG: begin
        for (int k = 0; k < NUM_CLUSTER; k++) begin
          if (cfgIdx_q == PTRW'(k)) begin
            clStartY_d[k*WIDTH +: WIDTH] = acc_q;
            pixCnt_d[k]   = '0;
            bufFull_d[k]  = 1'b0;
            doneFlag_d[k] = 1'b0;
          end
        end
        acc_d = acc_q + stepY;
        if (cfgIdx_q == PTRW'(NUM_CLUSTER - 1)) begin
          state_d = S_LAUNCH;
        end else begin
          cfgIdx_d = cfgIdx_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        for (int k = 0; k < NUM_CLUSTER; k++) begin
          if (cl_iter_vld[k] && !bufFull_q[k]) begin
            bufFull_d[k] = 1'b1;
            bufIter_d[k] = cl_iter[k*ITERW +: ITERW];
          end
          if (cl_done[k]) begin
            doneFlag_d[k] = 1'b1;
          end
        end
        if (&doneFlag_q && !(|bufFull_q) && !pixVld_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Round-robin: first full buffer after the last grant, wrapping around.
    for (int i = 1; i <= NUM_CLUSTER; i++) begin
      for (int k = 0; k < NUM_CLUSTER; k++) begin
        if (!found && bufFull_q[k] && ((int'(rrPtr_q) + i) % NUM_CLUSTER == k)) begin
          found = 1'b1;
          grant = PTRW'(k);
        end
      end
    end

    if (outFree) begin
      pixVld_d = found;
      for (int k = 0; k < NUM_CLUSTER; k++) begin
        if (found && grant == PTRW'(k)) begin
          pixIter_d    = bufIter_q[k];
          pixAddr_d    = bandBase(k) + pixCnt_q[k];
          pixCnt_d[k]  = pixCnt_q[k] + 1'b1;
          bufFull_d[k] = 1'b0;
        end
      end
      if (found) begin
        rrPtr_d = grant;
      end
    end
  end

  // The pointer resets to the last cluster so cluster 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      startX_q   <= '0;
      deltaX_q   <= '0;
      deltaY_q   <= '0;
      acc_q      <= '0;
      cfgIdx_q   <= '0;
      clStartY_q <= '0;
      bufFull_q  <= '0;
      bufIter_q  <= '{default: '0};
      doneFlag_q <= '0;
      pixCnt_q   <= '{default: '0};
      rrPtr_q    <= PTRW'(NUM_CLUSTER - 1);
      pixVld_q   <= 1'b0;
      pixAddr_q  <= '0;
      pixIter_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      startX_q   <= startX_d;
      deltaX_q   <= deltaX_d;
      deltaY_q   <= deltaY_d;
      acc_q      <= acc_d;
      cfgIdx_q   <= cfgIdx_d;
      clStartY_q <= clStartY_d;
      bufFull_q  <= bufFull_d;
      bufIter_q  <= bufIter_d;
      doneFlag_q <= doneFlag_d;
      pixCnt_q   <= pixCnt_d;
      rrPtr_q    <= rrPtr_d;
      pixVld_q   <= pixVld_d;
      pixAddr_q  <= pixAddr_d;
      pixIter_q  <= pixIter_d;
    end
  end

  assign busy       = busy_q;
  assign done       = (state_q == S_DONE);
  assign cl_start   = (state_q == S_LAUNCH) ? {NUM_CLUSTER{1'b1}} : {NUM_CLUSTER{1'b0}};
  assign cl_start_x = startX_q;
  assign cl_delta_x = deltaX_q;
  assign cl_delta_y = deltaY_q;
  assign cl_start_y = clStartY_q;
  assign cl_x_count = XCNT_SIZE'(H_RES - 1);
  assign cl_y_count = YCNT_SIZE'(BAND_ROWS - 1);
  assign cl_stall   = bufFull_q;
  assign pix_vld    = pixVld_q;
  assign pix_addr   = pixAddr_q;
  assign pix_iter   = pixIter_q;

endmodule

// File: tb/tb_mandbort_cluster_sched.sv
// Bench for mandbort_cluster_sched on a 2-cluster 4x4 screen: a directed cycle table,
// then randomised-ready full frames scored per address, start-in-RUN and mid-frame reset.
module tb_mandbort_cluster_sched;

  localparam int NC   = 2;
  localparam int W    = 16;
  localparam int IW   = 7;
  localparam int AW   = 4;
  localparam int NPIX = 16;
  localparam int BPIX = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  start_x, start_y, delta_x, delta_y;
  logic          busy, done;
  logic [NC-1:0] cl_start;
  logic [W-1:0]  cl_start_x, cl_delta_x, cl_delta_y;
  logic [NC*W-1:0] cl_start_y;
  logic [9:0]    cl_x_count, cl_y_count;
  logic [NC-1:0] cl_iter_vld;
  logic [NC*IW-1:0] cl_iter;
  logic [NC-1:0] cl_done;
  logic [NC-1:0] cl_stall;
  logic          pix_vld, pix_rdy;
  logic [AW-1:0] pix_addr;
  logic [IW-1:0] pix_iter;

  mandbort_cluster_sched #(
    .NUM_CLUSTER(NC), .WIDTH(W), .ITERW(IW), .XCNT_SIZE(10), .YCNT_SIZE(10),
    .H_RES(4), .V_RES(4), .ADDRW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .start_x(start_x), .start_y(start_y), .delta_x(delta_x), .delta_y(delta_y),
    .busy(busy), .done(done), .cl_start(cl_start),
    .cl_start_x(cl_start_x), .cl_delta_x(cl_delta_x), .cl_delta_y(cl_delta_y),
    .cl_start_y(cl_start_y), .cl_x_count(cl_x_count), .cl_y_count(cl_y_count),
    .cl_iter_vld(cl_iter_vld), .cl_iter(cl_iter), .cl_done(cl_done), .cl_stall(cl_stall),
    .pix_vld(pix_vld), .pix_rdy(pix_rdy), .pix_addr(pix_addr), .pix_iter(pix_iter)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        start;
    logic [15:0] startY;
    logic [1:0]  iterVld;
    logic [6:0]  iter0;
    logic [6:0]  iter1;
    logic        pixRdy;
    logic        expBusy;
    logic [1:0]  expClStart;
    logic [1:0]  expStall;
    logic        expPixVld;
    logic [3:0]  expAddr;
    logic [6:0]  expIter;
    logic [31:0] expStartY;
  } vec_t;

  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;

  int         seenCnt  [NPIX];
  logic [6:0] expIter  [NPIX];
  bit         expValid [NPIX];
  int         nextIdx  [NC];
  bit         doneSent [NC];

  function automatic vec_t mkVec(input logic st, input logic [15:0] sy, input logic [1:0] vld,
                                 input logic [6:0] i0, input logic [6:0] i1, input logic rdy,
                                 input logic eBusy, input logic [1:0] eCs, input logic [1:0] eSt,
                                 input logic ePv, input logic [3:0] eAddr, input logic [6:0] eIter,
                                 input logic [31:0] eSy);
    vec_t v;
    v.start = st; v.startY = sy; v.iterVld = vld; v.iter0 = i0; v.iter1 = i1; v.pixRdy = rdy;
    v.expBusy = eBusy; v.expClStart = eCs; v.expStall = eSt; v.expPixVld = ePv;
    v.expAddr = eAddr; v.expIter = eIter; v.expStartY = eSy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int a = 0; a < NPIX; a++) begin
      seenCnt[a] = 0; expIter[a] = '0; expValid[a] = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      nextIdx[k] = 0; doneSent[k] = 1'b0;
    end
  endtask

  // Cluster k emits its band in order, so its j-th result belongs to address k*BPIX+j.
  task automatic modelPulse(input int k, input logic [6:0] v, input bit chkStall);
    int a;
    if (chkStall) checkOutput($sformatf("cluster%0d_overrun", k), 32'(cl_stall[k]), 32'd0);
    a = k * BPIX + nextIdx[k];
    expIter[a]  = v;
    expValid[a] = 1'b1;
    nextIdx[k]++;
  endtask

  task automatic logHandshake();
    int a;
    a = int'(pix_addr);
    checks++;
    if (!expValid[a] || seenCnt[a] != 0 || pix_iter !== expIter[a]) begin
      failures++;
      $display("[TB] FAIL handshake addr=%0d: got iter=0x%0h seen=%0d produced=%0d, expected iter=0x%0h seen=0 produced=1",
               a, pix_iter, seenCnt[a], expValid[a], expIter[a]);
    end
    seenCnt[a]++;
  endtask

  task automatic tick();
    if (pix_vld && pix_rdy && !rst) logHandshake();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    start       = v.start;
    start_y     = v.startY;
    pix_rdy     = v.pixRdy;
    cl_done     = '0;
    cl_iter_vld = v.iterVld;
    cl_iter     = {v.iter1, v.iter0};
    if (v.iterVld[0]) modelPulse(0, v.iter0, 1'b1);
    if (v.iterVld[1]) modelPulse(1, v.iter1, 1'b1);
    tick();
  endtask

  task automatic checkRow(input int r, input vec_t v);
    checkOutput($sformatf("row%0d_busy", r), 32'(busy), 32'(v.expBusy));
    checkOutput($sformatf("row%0d_done", r), 32'(done), 32'd0);
    checkOutput($sformatf("row%0d_cl_start", r), 32'(cl_start), 32'(v.expClStart));
    checkOutput($sformatf("row%0d_cl_stall", r), 32'(cl_stall), 32'(v.expStall));
    checkOutput($sformatf("row%0d_pix_vld", r), 32'(pix_vld), 32'(v.expPixVld));
    checkOutput($sformatf("row%0d_cl_start_y", r), cl_start_y, v.expStartY);
    if (v.expPixVld) begin
      checkOutput($sformatf("row%0d_pix_addr", r), 32'(pix_addr), 32'(v.expAddr));
      checkOutput($sformatf("row%0d_pix_iter", r), 32'(pix_iter), 32'(v.expIter));
    end
  endtask

  // Drive the rest of the frame with random ready and random cluster activity until done.
  task automatic runRandom(input string tag);
    int         cyc;
    bit         seenDone;
    bit         exitLoop;
    logic       prevHold;
    logic [3:0] prevAddr;
    logic [6:0] prevIter;
    logic [6:0] v;
    cyc = 0; seenDone = 1'b0; exitLoop = 1'b0;
    start = 1'b0;
    while (!exitLoop && cyc < 3000) begin
      pix_rdy     = 1'($urandom_range(0, 1));
      cl_iter_vld = '0;
      cl_done     = '0;
      for (int k = 0; k < NC; k++) begin
        if (nextIdx[k] < BPIX) begin
          if (!cl_stall[k] && $urandom_range(0, 1) == 1) begin
            v = 7'($urandom_range(0, 127));
            cl_iter_vld[k] = 1'b1;
            cl_iter[k*IW +: IW] = v;
            modelPulse(k, v, 1'b0);
          end
        end else if (!doneSent[k]) begin
          cl_done[k]  = 1'b1;
          doneSent[k] = 1'b1;
        end
      end
      prevHold = pix_vld && !pix_rdy;
      prevAddr = pix_addr;
      prevIter = pix_iter;
      tick();
      cyc++;
      if (prevHold) begin
        checkOutput({tag, "_hold_vld"}, 32'(pix_vld), 32'd1);
        checkOutput({tag, "_hold_addr"}, 32'(pix_addr), 32'(prevAddr));
        checkOutput({tag, "_hold_iter"}, 32'(pix_iter), 32'(prevIter));
      end
      if (seenDone) begin
        checkOutput({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done_single"}, 32'(done), 32'd0);
        exitLoop = 1'b1;
      end else if (done) begin
        seenDone = 1'b1;
        checkOutput({tag, "_stall_at_done"}, 32'(cl_stall), 32'd0);
        checkOutput({tag, "_pix_vld_at_done"}, 32'(pix_vld), 32'd0);
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        for (int a = 0; a < NPIX; a++)
          checkOutput($sformatf("%s_addr%0d_once", tag, a), 32'(seenCnt[a]), 32'd1);
      end
    end
    if (!exitLoop) begin
      failures++;
      checks++;
      $display("[TB] FAIL %s_timeout: got no done within %0d cycles, expected done", tag, cyc);
    end
    cl_iter_vld = '0;
    cl_done     = '0;
    pix_rdy     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    start_x = 16'hE000; start_y = 16'h1000; delta_x = 16'h0010; delta_y = 16'h0100;
    cl_iter_vld = '0; cl_iter = '0; cl_done = '0; pix_rdy = 1'b1;
    resetModel();
    repeat (3) tick();
    rst = 1'b0;

    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_cl_start", 32'(cl_start), 32'd0);
    checkOutput("reset_cl_stall", 32'(cl_stall), 32'd0);
    checkOutput("reset_pix_vld", 32'(pix_vld), 32'd0);
    checkOutput("reset_pix_addr", 32'(pix_addr), 32'd0);
    checkOutput("reset_pix_iter", 32'(pix_iter), 32'd0);
    checkOutput("reset_cl_start_y", cl_start_y, 32'd0);
    checkOutput("reset_cl_start_x", 32'(cl_start_x), 32'd0);
    checkOutput("const_x_count", 32'(cl_x_count), 32'd3);
    checkOutput("const_y_count", 32'(cl_y_count), 32'd1);

    // Row expectations are the outputs right after the edge that consumes the row's inputs.
    vecs.push_back(mkVec(1, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h0000_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b11, 2'b00, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b11, 5, 9, 1, 1, 2'b00, 2'b11, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b10, 1, 0, 5, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 1, 8, 9, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(1, 16'h7777, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h7777, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b11, 3, 4, 0, 1, 2'b00, 2'b11, 0, 0, 0, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 0, 1, 2'b00, 2'b10, 1, 1, 3, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b01, 6, 0, 0, 1, 2'b00, 2'b11, 1, 1, 3, 32'h1200_1000));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 0, 1, 2'b00, 2'b11, 1, 1, 3, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b01, 1, 9, 4, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 1, 2, 6, 32'h1200_1000));
    vecs.push_back(mkVec(0, 16'h1000, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 32'h1200_1000));

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r]);
      checkRow(r, vecs[r]);
    end
    checkOutput("frame1_latched_start_x", 32'(cl_start_x), 32'hE000);
    checkOutput("frame1_latched_delta_x", 32'(cl_delta_x), 32'h0010);
    checkOutput("frame1_latched_delta_y", 32'(cl_delta_y), 32'h0100);
    runRandom("frame1");

    // Second frame: step wraps (0x8001*2 -> 0x0002), then abandoned by a reset mid-RUN.
    resetModel();
    start_x = 16'h0ABC; start_y = 16'hFF00; delta_x = 16'h0055; delta_y = 16'h8001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("frame2_cl_start", 32'(cl_start), 32'h3);
    checkOutput("frame2_cl_start_y_wrap", cl_start_y, 32'hFF02_FF00);
    checkOutput("frame2_start_x", 32'(cl_start_x), 32'h0ABC);
    checkOutput("frame2_delta_x", 32'(cl_delta_x), 32'h0055);
    checkOutput("frame2_delta_y", 32'(cl_delta_y), 32'h8001);
    tick();
    pix_rdy = 1'b0;
    cl_iter_vld = 2'b11;
    cl_iter = {7'd33, 7'd22};
    modelPulse(0, 7'd22, 1'b1);
    modelPulse(1, 7'd33, 1'b1);
    tick();
    cl_iter_vld = '0;
    tick();
    checkOutput("frame2_pending_vld", 32'(pix_vld), 32'd1);
    checkOutput("frame2_pending_stall", 32'(cl_stall), 32'h2);
    rst = 1'b1;
    tick();
    checkOutput("midreset_pix_vld", 32'(pix_vld), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_cl_stall", 32'(cl_stall), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_cl_start_y", cl_start_y, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("after_reset_busy", 32'(busy), 32'd0);
    checkOutput("after_reset_done", 32'(done), 32'd0);

    // Third frame from a clean reset.
    resetModel();
    start_y = 16'h1000; delta_y = 16'h0100;
    pix_rdy = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("frame3_busy", 32'(busy), 32'd1);
    tick();
    tick();
    checkOutput("frame3_cl_start", 32'(cl_start), 32'h3);
    checkOutput("frame3_cl_start_y", cl_start_y, 32'h1200_1000);
    tick();
    runRandom("frame3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
